// File: rtl/gray_pkg.sv
// Shared constants and types for the RGB888 -> 8-bit luma reader.
package gray_pkg;
  localparam logic [15:0] COEF_R     = 16'd77;
  localparam logic [15:0] COEF_G     = 16'd150;
  localparam logic [15:0] COEF_B     = 16'd29;
  localparam int          LUMA_SHIFT = 8;
  localparam int          PIPE_LAT   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [23:0] rgb;
  } pix_in_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] gray;
  } pix_out_t;
endpackage

// File: rtl/rgb_grayscale_reader_if.sv
// Frame-buffer read bus plus luma pixel stream toward the Sobel stage.
interface rgb_grayscale_reader_if #(parameter int ADDR_W = 16);
  logic              start_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_rd_o;
  logic [23:0]       mem_data_i;
  logic [7:0]        grayscale_o;
  logic              done_o;
  logic              busy_o;
  logic              frame_done_o;

  modport master (
    input  start_i, mem_data_i,
    output mem_addr_o, mem_rd_o, grayscale_o, done_o, busy_o, frame_done_o
  );

  modport slave (
    output start_i, mem_data_i,
    input  mem_addr_o, mem_rd_o, grayscale_o, done_o, busy_o, frame_done_o
  );
endinterface

// File: rtl/rgb_grayscale_reader_rgb2gray_pipe.sv
// Two-stage multiply / sum pipeline: products, then luma = sum >> 8.
module rgb2gray_pipe
  import gray_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  pix_in_t  in_i,
  output pix_out_t out_o
);
  logic [1:0]  vld_pipe_q, vld_pipe_d;
  logic [15:0] pr_q, pg_q, pb_q, pr_d, pg_d, pb_d;
  logic [7:0]  gray_q, gray_d;
  logic [15:0] sum;

  // Coefficients add up to 256, so the 16-bit sum cannot overflow.
  always_comb begin
    pr_d       = COEF_R * {8'h00, in_i.rgb[23:16]};
    pg_d       = COEF_G * {8'h00, in_i.rgb[15:8]};
    pb_d       = COEF_B * {8'h00, in_i.rgb[7:0]};
    vld_pipe_d = {vld_pipe_q[0], in_i.valid};
    sum        = pr_q + pg_q + pb_q;
    gray_d     = vld_pipe_q[0] ? sum[LUMA_SHIFT +: 8] : gray_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      pr_q       <= '0;
      pg_q       <= '0;
      pb_q       <= '0;
      gray_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      pr_q       <= pr_d;
      pg_q       <= pg_d;
      pb_q       <= pb_d;
      gray_q     <= gray_d;
    end
  end

  assign out_o.valid = vld_pipe_q[1];
  assign out_o.gray  = gray_q;
endmodule

// File: rtl/rgb_grayscale_reader.sv
// Raster-order frame reader: one RGB888 read per cycle, luma out after 3 cycles.
module rgb_grayscale_reader
  import gray_pkg::*;
#(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int ADDR_W     = 16
) (
  input logic                    clk,
  input logic                    rst,
  rgb_grayscale_reader_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [1:0]        DRAIN_INIT = 2'(PIPE_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        drain_q, drain_d;
  logic              s1_vld_q;
  pix_in_t           pipe_in;
  pix_out_t          pipe_out;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (bus.start_i) state_d = ST_READ;
      end
      ST_READ: begin
        // Last address holds rather than wrapping; also covers N=1.
        if (addr_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'd0) state_d = ST_DONE;
        else                 drain_d = drain_q - 1'b1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      drain_q  <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      drain_q  <= drain_d;
      s1_vld_q <= bus.mem_rd_o;
    end
  end

  assign pipe_in.valid = s1_vld_q;
  assign pipe_in.rgb   = bus.mem_data_i;

  rgb2gray_pipe u_pipe (
    .clk   (clk),
    .rst   (rst),
    .in_i  (pipe_in),
    .out_o (pipe_out)
  );

  assign bus.mem_rd_o     = (state_q == ST_READ);
  assign bus.mem_addr_o   = addr_q;
  assign bus.busy_o       = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign bus.frame_done_o = (state_q == ST_DONE);
  assign bus.done_o       = pipe_out.valid;
  assign bus.grayscale_o  = pipe_out.gray;
endmodule
